// File: rtl/mppt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mppt_pkg
//  Purpose  : Shared types and constants for the beacon power-mode controller
//             and the MPPT signal block (mode encodings, PWM width, defaults).
//  Revision : 1.0 - initial release
// ============================================================================
package mppt_pkg;

    // Power modes; the MPPT block decodes state_number with this same type.
    typedef enum logic [2:0] {
        MODE_STARTUP = 3'd0,
        MODE_CHARGE  = 3'd1,
        MODE_BOOST   = 3'd2,
        MODE_LED_RUN = 3'd3,
        MODE_SLEEP   = 3'd4
    } mode_t;

    localparam int PWM_BITS               = 10;
    localparam int DWELL_CYCLES_DEFAULT   = 1024;
    localparam int STARTUP_CYCLES_DEFAULT = 4096;

    // Transition candidate: the highest-priority exit the current mode wants.
    typedef struct packed {
        logic  valid;
        mode_t target;
    } cand_t;

    localparam cand_t CAND_NONE = '{valid: 1'b0, target: MODE_SLEEP};

    // Gate enables for a mode, ordered {buck, boost, led}.
    function automatic logic [2:0] gate_enables(input mode_t mode);
        logic [2:0] en;
        en = 3'b000;
        case (mode)
            MODE_CHARGE:  en = 3'b100;
            MODE_BOOST:   en = 3'b010;
            MODE_LED_RUN: en = 3'b001;
            default:      en = 3'b000;
        endcase
        return en;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mppt_state_ctrl_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_gen
//  Purpose  : Free-running PWM counter with a period-boundary duty latch.
//             The registered compare result is steered onto one of three
//             gate lines by the enable vector and can be forced low.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_gen
    import mppt_pkg::*;
#(
    parameter int WIDTH = PWM_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] val,
    input  logic [2:0]       en,
    input  logic             force_low,
    output logic [2:0]       gate
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_duty;
    logic [2:0]       r_gate;
    logic             w_cmp;

    assign w_cmp = (r_cnt < r_duty);

    // Counter wraps naturally; duty only reloads on the last count of a
    // period so a new command never truncates or stretches a running pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_gate <= 3'b000;
        end else begin
            r_cnt <= r_cnt + WIDTH'(1);
            if (r_cnt == {WIDTH{1'b1}}) begin
                r_duty <= val;
            end
            r_gate <= (w_cmp && !force_low) ? en : 3'b000;
        end
    end

    assign gate = r_gate;

endmodule
`default_nettype wire

// File: rtl/mppt_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mppt_state_ctrl
//  Purpose  : Beacon power-mode FSM with dwell-filtered transitions, feeding
//             the buck / boost / LED-driver gate PWMs with a dead-time cycle
//             on every mode change.
//  Revision : 1.0 - initial release
// ============================================================================
module mppt_state_ctrl
    import mppt_pkg::*;
#(
    parameter int DWELL_CYCLES   = DWELL_CYCLES_DEFAULT,
    parameter int STARTUP_CYCLES = STARTUP_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cap_charged,
    input  logic                cap_over5,
    input  logic                PV_power_high,
    input  logic                pwr_low,
    input  logic [PWM_BITS-1:0] val,
    output logic [2:0]          state_number,
    output logic                buck_pwm,
    output logic                boost_pwm,
    output logic                led_pwm,
    output logic                state_change
);

    localparam int DW_W = $clog2(DWELL_CYCLES);
    localparam int ST_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

    // The count is advanced on the edge itself, so a candidate that has
    // already been confirmed DWELL_CYCLES-2 times is on its final cycle.
    localparam logic [DW_W-1:0] DWELL_LAST   = DW_W'(DWELL_CYCLES - 2);
    localparam logic [ST_W-1:0] STARTUP_LAST = ST_W'(STARTUP_CYCLES - 1);

    mode_t            r_state;
    mode_t            w_next_state;
    cand_t            w_cand;
    cand_t            r_prev_cand;
    logic [DW_W-1:0]  r_dwell;
    logic [ST_W-1:0]  r_startup;
    logic             r_state_change;
    logic             w_qualify;
    logic             w_dwell_done;
    logic             w_transition;
    logic [2:0]       w_gate;

    // Highest-priority exit condition of the current mode, if any.
    always_comb begin
        w_cand = CAND_NONE;
        case (r_state)
            MODE_CHARGE: begin
                if (pwr_low)          w_cand = '{valid: 1'b1, target: MODE_SLEEP};
                else if (cap_charged) w_cand = '{valid: 1'b1, target: MODE_LED_RUN};
            end
            MODE_LED_RUN: begin
                if (pwr_low)             w_cand = '{valid: 1'b1, target: MODE_SLEEP};
                else if (!cap_over5)     w_cand = '{valid: 1'b1, target: MODE_CHARGE};
                else if (!PV_power_high) w_cand = '{valid: 1'b1, target: MODE_BOOST};
            end
            MODE_BOOST: begin
                if (!cap_over5)         w_cand = '{valid: 1'b1, target: MODE_SLEEP};
                else if (PV_power_high) w_cand = '{valid: 1'b1, target: MODE_LED_RUN};
            end
            MODE_SLEEP: begin
                if (PV_power_high) w_cand = '{valid: 1'b1, target: MODE_CHARGE};
            end
            default: w_cand = CAND_NONE;
        endcase
    end

    assign w_qualify    = w_cand.valid && (w_cand == r_prev_cand);
    assign w_dwell_done = w_qualify && (r_dwell == DWELL_LAST);

    // Next-state decode; illegal codes fall straight to SLEEP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MODE_STARTUP: begin
                if (r_startup == STARTUP_LAST) w_next_state = MODE_CHARGE;
            end
            MODE_CHARGE, MODE_LED_RUN, MODE_BOOST, MODE_SLEEP: begin
                if (w_dwell_done) w_next_state = w_cand.target;
            end
            default: w_next_state = MODE_SLEEP;
        endcase
    end

    assign w_transition = (w_next_state != r_state);

    // State register and change pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= MODE_STARTUP;
            r_state_change <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_state_change <= w_transition;
        end
    end

    // Dwell filter: count consecutive cycles of an unchanged candidate.
    always_ff @(posedge clk) begin
        if (reset || w_transition) begin
            r_dwell     <= '0;
            r_prev_cand <= CAND_NONE;
        end else begin
            r_dwell     <= w_qualify ? (r_dwell + DW_W'(1)) : '0;
            r_prev_cand <= w_cand;
        end
    end

    // Startup hold-off counter, only live while in STARTUP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_startup <= '0;
        end else if ((r_state == MODE_STARTUP) && !w_transition) begin
            r_startup <= r_startup + ST_W'(1);
        end else begin
            r_startup <= '0;
        end
    end

    // Gates follow the mode being entered; the change cycle is dead time.
    pwm_gen #(
        .WIDTH (PWM_BITS)
    ) u_pwm_gen (
        .clk       (clk),
        .reset     (reset),
        .val       (val),
        .en        (gate_enables(w_next_state)),
        .force_low (w_transition),
        .gate      (w_gate)
    );

    assign state_number = r_state;
    assign state_change = r_state_change;
    assign buck_pwm     = w_gate[2];
    assign boost_pwm    = w_gate[1];
    assign led_pwm      = w_gate[0];

endmodule
`default_nettype wire

// File: tb/tb_mppt_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mppt_state_ctrl
//  Purpose  : Self-checking bench for mppt_state_ctrl (DWELL=4, STARTUP=8).
//             Expected outputs are queued as stimulus is applied and popped
//             when the DUT responds on the following edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mppt_state_ctrl;
    import mppt_pkg::*;

    localparam int DW = 4;
    localparam int ST = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cap_charged = 1'b0;
    logic       cap_over5 = 1'b1;
    logic       PV_power_high = 1'b1;
    logic       pwr_low = 1'b0;
    logic [9:0] val = 10'd0;
    logic [2:0] state_number;
    logic       buck_pwm;
    logic       boost_pwm;
    logic       led_pwm;
    logic       state_change;

    int compared   = 0;
    int mismatched = 0;

    // Expected per-edge outputs; pw is {buck, boost, led}.
    typedef struct {
        logic [2:0] st;
        logic       sc;
        logic [2:0] pw;
    } exp_t;

    // Flag schedule entry: f = {cap_charged, cap_over5, PV_power_high, pwr_low}.
    typedef struct {
        logic [3:0] f;
        logic [2:0] st;
        logic       sc;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];

    // Reference PWM timing: counter and duty latch as seen from the pins.
    logic [9:0] m_cnt  = 10'd0;
    logic [9:0] m_duty = 10'd0;

    mppt_state_ctrl #(
        .DWELL_CYCLES   (DW),
        .STARTUP_CYCLES (ST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cap_charged   (cap_charged),
        .cap_over5     (cap_over5),
        .PV_power_high (PV_power_high),
        .pwr_low       (pwr_low),
        .val           (val),
        .state_number  (state_number),
        .buck_pwm      (buck_pwm),
        .boost_pwm     (boost_pwm),
        .led_pwm       (led_pwm),
        .state_change  (state_change)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] pw_of(input logic [2:0] st, input logic sc, input logic cmp);
        if (sc || !cmp) return 3'b000;
        case (st)
            3'd1:    return 3'b100;
            3'd2:    return 3'b010;
            3'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Queue what the outputs must be after the coming edge.
    task automatic push_exp(input logic [2:0] st, input logic sc);
        logic cmp;
        exp_t e;
        cmp  = !reset && (m_cnt < m_duty);
        e.st = st;
        e.sc = sc;
        e.pw = pw_of(st, sc, cmp);
        exp_q.push_back(e);
    endtask

    task automatic add(input logic [3:0] f, input logic [2:0] st, input logic sc, input int n);
        vec_t v;
        v.f  = f;
        v.st = st;
        v.sc = sc;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    // Advance one clock; outputs are sampled 1 unit after the rising edge.
    task automatic step();
        if (reset) begin
            m_cnt  = 10'd0;
            m_duty = 10'd0;
        end else begin
            if (m_cnt == 10'd1023) m_duty = val;
            m_cnt = m_cnt + 10'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_exp(3'd0, 1'b0);
            step();
            e = exp_q.pop_front();
            compared++;
            if ({state_number, state_change, buck_pwm, boost_pwm, led_pwm} !== {e.st, e.sc, e.pw}) begin
                mismatched++;
                $display("FAIL reset: got st=%0d sc=%b pw=%b%b%b, expected st=%0d sc=%b pw=%b",
                         state_number, state_change, buck_pwm, boost_pwm, led_pwm, e.st, e.sc, e.pw);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= ST; i++) begin
            push_exp((i == ST) ? 3'd1 : 3'd0, (i == ST));
            step();
            e = exp_q.pop_front();
            compared++;
            if ({state_number, state_change, buck_pwm, boost_pwm, led_pwm} !== {e.st, e.sc, e.pw}) begin
                mismatched++;
                $display("FAIL startup[%0d]: got st=%0d sc=%b pw=%b%b%b, expected st=%0d sc=%b pw=%b",
                         i, state_number, state_change, buck_pwm, boost_pwm, led_pwm, e.st, e.sc, e.pw);
            end
        end
    endtask

    task automatic test_pwm();
        exp_t e;
        int   want[4] = '{0, 256, 256, 512};
        int   highs;
        int   n;
        val = 10'd256;
        for (int ph = 0; ph < 4; ph++) begin
            highs = 0;
            n     = 0;
            do begin
                if (ph == 2 && n == 100) val = 10'd512;
                push_exp(3'd1, 1'b0);
                step();
                e = exp_q.pop_front();
                compared++;
                if ({state_number, state_change, buck_pwm, boost_pwm, led_pwm} !== {e.st, e.sc, e.pw}) begin
                    mismatched++;
                    $display("FAIL pwm_cycle ph%0d n=%0d: got st=%0d sc=%b pw=%b%b%b, expected st=%0d sc=%b pw=%b",
                             ph, n, state_number, state_change, buck_pwm, boost_pwm, led_pwm, e.st, e.sc, e.pw);
                end
                highs += int'(buck_pwm);
                n++;
            end while (m_cnt != 10'd0 && n < 1100);
            if (ph > 0) begin
                compared++;
                if (highs != want[ph] || n != 1024) begin
                    mismatched++;
                    $display("FAIL pwm_duty ph%0d: got %0d high in %0d cycles, expected %0d high in 1024",
                             ph, highs, n, want[ph]);
                end
            end
        end
    endtask

    task automatic test_dwell_filter();
        exp_t e;
        vec_t v;
        tbl.delete();
        add(4'b1110, 3'd1, 1'b0, 3);
        add(4'b0110, 3'd1, 1'b0, 1);
        add(4'b1110, 3'd1, 1'b0, 3);
        add(4'b1110, 3'd3, 1'b1, 1);
        add(4'b1110, 3'd3, 1'b0, 1);
        while (tbl.size() > 0) begin
            v = tbl.pop_front();
            {cap_charged, cap_over5, PV_power_high, pwr_low} = v.f;
            push_exp(v.st, v.sc);
            step();
            e = exp_q.pop_front();
            compared++;
            if ({state_number, state_change, buck_pwm, boost_pwm, led_pwm} !== {e.st, e.sc, e.pw}) begin
                mismatched++;
                $display("FAIL dwell flags=%b: got st=%0d sc=%b pw=%b%b%b, expected st=%0d sc=%b pw=%b",
                         v.f, state_number, state_change, buck_pwm, boost_pwm, led_pwm, e.st, e.sc, e.pw);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        vec_t v;
        tbl.delete();
        // LED_RUN with every exit true at once: SLEEP wins.
        add(4'b0001, 3'd3, 1'b0, 3);
        add(4'b0001, 3'd4, 1'b1, 1);
        add(4'b0001, 3'd4, 1'b0, 1);
        // Back to LED_RUN through CHARGE.
        add(4'b0110, 3'd4, 1'b0, 3);
        add(4'b0110, 3'd1, 1'b1, 1);
        add(4'b1110, 3'd1, 1'b0, 3);
        add(4'b1110, 3'd3, 1'b1, 1);
        // BOOST candidate for two cycles, then pwr_low takes over and restarts.
        add(4'b0100, 3'd3, 1'b0, 2);
        add(4'b0101, 3'd3, 1'b0, 3);
        add(4'b0101, 3'd4, 1'b1, 1);
        add(4'b0101, 3'd4, 1'b0, 1);
        while (tbl.size() > 0) begin
            v = tbl.pop_front();
            {cap_charged, cap_over5, PV_power_high, pwr_low} = v.f;
            push_exp(v.st, v.sc);
            step();
            e = exp_q.pop_front();
            compared++;
            if ({state_number, state_change, buck_pwm, boost_pwm, led_pwm} !== {e.st, e.sc, e.pw}) begin
                mismatched++;
                $display("FAIL priority flags=%b: got st=%0d sc=%b pw=%b%b%b, expected st=%0d sc=%b pw=%b",
                         v.f, state_number, state_change, buck_pwm, boost_pwm, led_pwm, e.st, e.sc, e.pw);
            end
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        // Sitting in SLEEP with no exit; jam the state register to code 6.
        {cap_charged, cap_over5, PV_power_high, pwr_low} = 4'b0101;
        force dut.r_state = mode_t'(3'd6);
        step();
        compared++;
        if (state_change !== 1'b1 || {buck_pwm, boost_pwm, led_pwm} !== 3'b000) begin
            mismatched++;
            $display("FAIL illegal_exit: got sc=%b pw=%b%b%b, expected sc=1 pw=000",
                     state_change, buck_pwm, boost_pwm, led_pwm);
        end
        release dut.r_state;
        step();
        compared++;
        if ({buck_pwm, boost_pwm, led_pwm} !== 3'b000) begin
            mismatched++;
            $display("FAIL illegal_pwm: got pw=%b%b%b, expected 000", buck_pwm, boost_pwm, led_pwm);
        end
        for (int i = 0; i < 3; i++) begin
            push_exp(3'd4, 1'b0);
            step();
            e = exp_q.pop_front();
            compared++;
            if ({state_number, state_change, buck_pwm, boost_pwm, led_pwm} !== {e.st, e.sc, e.pw}) begin
                mismatched++;
                $display("FAIL illegal_sleep[%0d]: got st=%0d sc=%b pw=%b%b%b, expected st=%0d sc=%b pw=%b",
                         i, state_number, state_change, buck_pwm, boost_pwm, led_pwm, e.st, e.sc, e.pw);
            end
        end
    endtask

    task automatic test_boost_reset();
        exp_t e;
        vec_t v;
        int   guard;
        logic seen_high;
        tbl.delete();
        add(4'b0110, 3'd4, 1'b0, 3);
        add(4'b0110, 3'd1, 1'b1, 1);
        add(4'b1110, 3'd1, 1'b0, 3);
        add(4'b1110, 3'd3, 1'b1, 1);
        add(4'b0100, 3'd3, 1'b0, 3);
        add(4'b0100, 3'd2, 1'b1, 1);
        while (tbl.size() > 0) begin
            v = tbl.pop_front();
            {cap_charged, cap_over5, PV_power_high, pwr_low} = v.f;
            push_exp(v.st, v.sc);
            step();
            e = exp_q.pop_front();
            compared++;
            if ({state_number, state_change, buck_pwm, boost_pwm, led_pwm} !== {e.st, e.sc, e.pw}) begin
                mismatched++;
                $display("FAIL to_boost flags=%b: got st=%0d sc=%b pw=%b%b%b, expected st=%0d sc=%b pw=%b",
                         v.f, state_number, state_change, buck_pwm, boost_pwm, led_pwm, e.st, e.sc, e.pw);
            end
        end
        // Run in BOOST until the boost gate is due high.
        guard     = 0;
        seen_high = 1'b0;
        while (!seen_high && guard < 1100) begin
            push_exp(3'd2, 1'b0);
            step();
            e = exp_q.pop_front();
            compared++;
            if ({state_number, state_change, buck_pwm, boost_pwm, led_pwm} !== {e.st, e.sc, e.pw}) begin
                mismatched++;
                $display("FAIL boost_run: got st=%0d sc=%b pw=%b%b%b, expected st=%0d sc=%b pw=%b",
                         state_number, state_change, buck_pwm, boost_pwm, led_pwm, e.st, e.sc, e.pw);
            end
            seen_high = (e.pw == 3'b010);
            guard++;
        end
        compared++;
        if (!seen_high) begin
            mismatched++;
            $display("FAIL boost_high_timeout: got no high cycle in %0d, expected one", guard);
        end
        // Reset mid-BOOST, then a full startup again.
        reset = 1'b1;
        push_exp(3'd0, 1'b0);
        step();
        e = exp_q.pop_front();
        compared++;
        if ({state_number, state_change, buck_pwm, boost_pwm, led_pwm} !== {e.st, e.sc, e.pw}) begin
            mismatched++;
            $display("FAIL reset_mid_boost: got st=%0d sc=%b pw=%b%b%b, expected st=%0d sc=%b pw=%b",
                     state_number, state_change, buck_pwm, boost_pwm, led_pwm, e.st, e.sc, e.pw);
        end
        reset = 1'b0;
        {cap_charged, cap_over5, PV_power_high, pwr_low} = 4'b0110;
        for (int i = 1; i <= ST + 1; i++) begin
            push_exp((i >= ST) ? 3'd1 : 3'd0, (i == ST));
            step();
            e = exp_q.pop_front();
            compared++;
            if ({state_number, state_change, buck_pwm, boost_pwm, led_pwm} !== {e.st, e.sc, e.pw}) begin
                mismatched++;
                $display("FAIL restart[%0d]: got st=%0d sc=%b pw=%b%b%b, expected st=%0d sc=%b pw=%b",
                         i, state_number, state_change, buck_pwm, boost_pwm, led_pwm, e.st, e.sc, e.pw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pwm();
        test_dwell_filter();
        test_priority();
        test_illegal();
        test_boost_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mppt_state_ctrl.md
# mppt_state_ctrl

Beacon power-mode controller and PWM stage for the solar/supercapacitor supply. It consumes the qualification flags (`cap_charged`, `cap_over5`, `PV_power_high`, `pwr_low`) and the 10-bit control value `val` from the MPPT signal block. It returns `state_number` to that block and drives the buck, boost and LED-driver gate PWMs. Each mode change is filtered by a dwell counter so that flag chatter cannot toggle the converters.

## Interface
- `DWELL_CYCLES`, 1024: consecutive cycles a transition condition must hold before the state changes (≥2).
- `STARTUP_CYCLES`, 4096: cycles spent in STARTUP after reset (≥1).
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `cap_charged` input 1: cap above full threshold.
- `cap_over5` input 1: cap above 5 V.
- `PV_power_high` input 1: panel power above threshold.
- `pwr_low` input 1: neither panel nor cap can sustain load.
- `val` input 10: duty command from MPPT block; duty = val/1024.
- `state_number` output 3: current mode, fed back to MPPT block.
- `buck_pwm` output 1: buck gate drive.
- `boost_pwm` output 1: boost gate drive.
- `led_pwm` output 1: LED-driver gate drive.
- `state_change` output 1: one-cycle pulse on the cycle `state_number` takes a new value.

## Operation
- States and encodings:
  - STARTUP=0
  - CHARGE=1 (buck charges cap)
  - BOOST=2 (cap supplies LEDs via boost)
  - LED_RUN=3 (panel drives LEDs)
  - SLEEP=4 (all off)
  - Codes 5–7 are illegal and go to SLEEP on the next edge.
- Transitions. Exit conditions are listed per state in priority order; only the highest-priority true condition is candidate:
  - STARTUP → CHARGE: startup counter reaches STARTUP_CYCLES−1. Flags are ignored in STARTUP.
  - CHARGE → SLEEP: `pwr_low`.
  - CHARGE → LED_RUN: `cap_charged`.
  - LED_RUN → SLEEP: `pwr_low`.
  - LED_RUN → CHARGE: `!cap_over5`.
  - LED_RUN → BOOST: `!PV_power_high`.
  - BOOST → SLEEP: `!cap_over5`.
  - BOOST → LED_RUN: `PV_power_high`.
  - SLEEP → CHARGE: `PV_power_high`.
- Dwell qualification: a single dwell counter, 0..DWELL_CYCLES−1.
  - Increments each cycle the candidate target is non-null and equal to the previous cycle's candidate.
  - Otherwise it reloads to 0 if a candidate exists, or clears to 0 if none does.
  - The state transitions on the edge where the counter equals DWELL_CYCLES−1 and the same candidate is still true.
  - The counter clears on every transition.
  - A candidate switching to a higher-priority one restarts the count.
- PWM generation:
  - Free-running 10-bit `pwm_cnt`, wraps 1023→0. Period is 1024 cycles.
  - `duty` latch loads `val` only when `pwm_cnt`==1023, so changes in `val` take effect at the next period start.
  - Active output = registered (`pwm_cnt` < `duty`). val=0 gives always low; val=1023 gives high 1023 of 1024 cycles.
  - `buck_pwm` is active only in CHARGE, `boost_pwm` only in BOOST, `led_pwm` only in LED_RUN. At most one output is high in any cycle.
  - On a state change, all PWMs are forced low for the first cycle in the new state (dead time). The new output starts on the next cycle using the current `duty`.
- Reset mid-operation: all counters, `duty` and the state return to reset values on the next edge. PWMs go low on that edge.

## Timing
- Reset values: `state_number`=0, all PWMs 0, `state_change`=0, `pwm_cnt`=0, `duty`=0, dwell=0, startup counter=0.
- All outputs are registered.
- Flag to state latency: a condition true from cycle t with no interruption gives the new `state_number` at edge t+DWELL_CYCLES.
- `state_change` is asserted in the same cycle the new `state_number` is first visible.
- `val` to PWM latency: at most one PWM period plus one cycle.
- No handshake with the MPPT block. It samples `state_number` combinationally each cycle.

## Structure
- Shared package `mppt_pkg`:
  - enum `mode_t` (3-bit, the encodings above)
  - `PWM_BITS`=10
  - dwell/startup default constants
  - The MPPT block adopts `mode_t` for its `state_number` case decode.
- Sub-module `pwm_gen`: counter, period-boundary duty latch, compare, enable, force-low. Instantiated once; its compare output is steered to the three gate outputs by state.

## Test plan
- Reset with DWELL_CYCLES=4, STARTUP_CYCLES=8 → `state_number`=0, PWMs low for 8 cycles, then 1 with a `state_change` pulse.
- In CHARGE, hold `cap_charged` for 3 cycles then drop it, then hold it for 4 cycles → no change after the first burst; `state_number`=3 exactly 4 edges after the second assertion.
- In LED_RUN, assert `!cap_over5` and `pwr_low` together for 4 cycles → SLEEP (priority). `!PV_power_high` alone then switched to `pwr_low` mid-count → dwell restarts.
- CHARGE with val=256 → `buck_pwm` high 256 of each 1024 cycles. Changing val to 512 mid-period → the old duty completes, the new duty starts at `pwm_cnt`=0.
- Force illegal state via reset-release glitch/backdoor to 6 → SLEEP next edge; all PWMs low in every cycle.
- Assert `reset` mid-BOOST with `boost_pwm` high → next edge `state_number`=0 and all outputs 0.
